// File: rtl/axi_lite_reg_bank_pkg.sv
// axi_reg_bank_pkg
// Shared definitions for the AXI4-Lite register bank: response encodings,
// write/read FSM state types and the address-to-register-index decoder.
package axi_reg_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    typedef struct packed {
        logic [31:0] idx;
        logic        oor;
    } reg_sel_t;

    // The byte-offset bits below the word size are dropped. Any index bit
    // above bit 31 also counts as out of range.
    function automatic reg_sel_t decode_addr(input logic [63:0] addr,
                                             input int unsigned shift,
                                             input int unsigned num_regs);
        reg_sel_t    sel;
        logic [63:0] full;
        full    = addr >> shift;
        sel.idx = full[31:0];
        sel.oor = (full[63:32] != '0) || (full[31:0] >= num_regs);
        return sel;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank_if.sv
// axi_lite_reg_bank_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, data, VALIDs and B/R READYs
//   slave  modport : drives AW/W/AR READYs, B and R channels
interface axi_lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID,    input WREADY,
        input  BRESP, BVALID,           output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID,    output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID,    output WREADY,
        output BRESP, BVALID,           input BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID,    input RREADY
    );

endinterface

// File: rtl/axi_lite_reg_bank_wr_fsm.sv
// axi_reg_bank_wr_fsm
// Joins the AW and W channels (either order or together), emits a single
// commit strobe with the address/data/strobe of the transaction, and runs
// the B channel.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_aw*/o_awready      : AW channel
//   i_w*/o_wready        : W channel
//   o_b*/i_bready        : B channel
//   o_commit, o_cm_*     : commit strobe and transaction contents (combinational)
//   i_cm_oor             : out-of-range flag for o_cm_addr, decoded by the parent
//
// state     | meaning
// W_IDLE    | nothing captured, both AW and W accepted
// W_HAVE_AW | address captured, waiting for W
// W_HAVE_W  | data captured, waiting for AW
// W_RESP    | committed, BVALID held until BREADY
module axi_reg_bank_wr_fsm
    import axi_reg_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_commit,
    output logic [ADDR_WIDTH-1:0]   o_cm_addr,
    output logic [DATA_WIDTH-1:0]   o_cm_data,
    output logic [DATA_WIDTH/8-1:0] o_cm_strb,
    input  logic                    i_cm_oor
);

    wr_state_t               r_state;
    wr_state_t               w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [1:0]              r_bresp;
    logic                    w_aw_hs;
    logic                    w_w_hs;

    // READYs are gated by reset so nothing is offered while ARESETN is low.
    always_comb begin
        w_state_nxt = r_state;
        o_awready   = 1'b0;
        o_wready    = 1'b0;
        o_commit    = 1'b0;
        case (r_state)
            W_IDLE: begin
                o_awready = i_rst_n;
                o_wready  = i_rst_n;
                if (i_rst_n) begin
                    if (i_awvalid && i_wvalid) begin
                        o_commit    = 1'b1;
                        w_state_nxt = W_RESP;
                    end else if (i_awvalid) begin
                        w_state_nxt = W_HAVE_AW;
                    end else if (i_wvalid) begin
                        w_state_nxt = W_HAVE_W;
                    end
                end
            end
            W_HAVE_AW: begin
                o_wready = i_rst_n;
                if (i_rst_n && i_wvalid) begin
                    o_commit    = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_HAVE_W: begin
                o_awready = i_rst_n;
                if (i_rst_n && i_awvalid) begin
                    o_commit    = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs = o_awready & i_awvalid;
    assign w_w_hs  = o_wready & i_wvalid;

    // On the completing edge the later channel's values are still on the bus.
    assign o_cm_addr = (r_state == W_HAVE_AW) ? r_awaddr : i_awaddr;
    assign o_cm_data = (r_state == W_HAVE_W)  ? r_wdata  : i_wdata;
    assign o_cm_strb = (r_state == W_HAVE_W)  ? r_wstrb  : i_wstrb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_awaddr <= i_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
            if (o_commit) begin
                r_bresp <= i_cm_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign o_bvalid = (r_state == W_RESP);
    assign o_bresp  = r_bresp;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank
// AXI4-Lite slave register bank: NUM_RW read/write control registers
// followed by NUM_RO read-only status registers, with byte strobes,
// SLVERR for out-of-range indices and a per-register write pulse.
//   ACLK, ARESETN  : clock, async active-low reset
//   bus            : AXI4-Lite slave port (axi_lite_reg_bank_if.slave)
//   reg_q          : RW register contents, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse   : one-cycle strobe per RW register after each write commit
//   status_in      : status sources for the RO registers, same packing
// Optional build macro AXI_REG_BANK_W1C_EN: RO registers become sticky
// (set by status_in, cleared by writing 1); otherwise they read status_in live.
//
// state  | meaning
// R_IDLE | ARREADY high, waiting for AR
// R_RESP | RDATA/RRESP held, RVALID high until RREADY
module axi_lite_reg_bank
    import axi_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_RW     = 8,
    parameter int                    NUM_RO     = 4,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                                           ACLK,
    input  logic                                           ARESETN,
    axi_lite_reg_bank_if.slave                             bus,
    output logic [NUM_RW*DATA_WIDTH-1:0]                   reg_q,
    output logic [NUM_RW-1:0]                              reg_wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in
);

    localparam int          NRO      = (NUM_RO > 0) ? NUM_RO : 1;
    localparam int          STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned SHIFT    = $clog2(STRB_W);
    localparam int unsigned NUM_REGS = NUM_RW + NUM_RO;

    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_cm_addr;
    logic [DATA_WIDTH-1:0] w_cm_data;
    logic [STRB_W-1:0]     w_cm_strb;
    reg_sel_t              w_cm_sel;
    reg_sel_t              w_ar_sel;

    logic [DATA_WIDTH-1:0] r_reg [NUM_RW];
    logic [NUM_RW-1:0]     r_wr_pulse;
    logic [DATA_WIDTH-1:0] w_ro_val [NRO];

    rd_state_t             r_rstate;
    rd_state_t             w_rstate_nxt;
    logic                  w_arready;
    logic                  w_ar_hs;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_unused_prot;

    assign w_unused_prot = ^{bus.AWPROT, bus.ARPROT};

    axi_reg_bank_wr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_fsm (
        .i_clk     (ACLK),
        .i_rst_n   (ARESETN),
        .i_awaddr  (bus.AWADDR),
        .i_awvalid (bus.AWVALID),
        .o_awready (bus.AWREADY),
        .i_wdata   (bus.WDATA),
        .i_wstrb   (bus.WSTRB),
        .i_wvalid  (bus.WVALID),
        .o_wready  (bus.WREADY),
        .o_bresp   (bus.BRESP),
        .o_bvalid  (bus.BVALID),
        .i_bready  (bus.BREADY),
        .o_commit  (w_commit),
        .o_cm_addr (w_cm_addr),
        .o_cm_data (w_cm_data),
        .o_cm_strb (w_cm_strb),
        .i_cm_oor  (w_cm_sel.oor)
    );

    assign w_cm_sel = decode_addr(64'(w_cm_addr), SHIFT, NUM_REGS);
    assign w_ar_sel = decode_addr(64'(bus.ARADDR), SHIFT, NUM_REGS);

    // RW register array
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_RW; k++) begin
                r_reg[k] <= RST_VAL;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                if (w_commit && !w_cm_sel.oor && (w_cm_sel.idx == 32'(k))) begin
                    r_wr_pulse[k] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_cm_strb[b]) begin
                            r_reg[k][b*8 +: 8] <= w_cm_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_reg_q
        assign reg_q[k*DATA_WIDTH +: DATA_WIDTH] = r_reg[k];
    end

    assign reg_wr_pulse = r_wr_pulse;

`ifdef AXI_REG_BANK_W1C_EN
    logic [DATA_WIDTH-1:0] r_sticky [NRO];
    logic [DATA_WIDTH-1:0] w_clr [NRO];
    logic [DATA_WIDTH-1:0] w_strb_mask;

    always_comb begin
        w_strb_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            w_strb_mask[b*8 +: 8] = {8{w_cm_strb[b]}};
        end
    end

    always_comb begin
        for (int k = 0; k < NRO; k++) begin
            w_clr[k] = '0;
            if ((k < NUM_RO) && w_commit && !w_cm_sel.oor &&
                (w_cm_sel.idx == 32'(NUM_RW + k))) begin
                w_clr[k] = w_cm_data & w_strb_mask;
            end
        end
    end

    // Set term is applied after the clear so a live status bit survives a
    // simultaneous write-1-to-clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NRO; k++) begin
                r_sticky[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NRO; k++) begin
                r_sticky[k] <= (r_sticky[k] & ~w_clr[k]) |
                               status_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NRO; k++) begin
            w_ro_val[k] = r_sticky[k];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NRO; k++) begin
            w_ro_val[k] = status_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`endif

    // Read FSM
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_ar_hs      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = ARESETN;
                if (ARESETN && bus.ARVALID) begin
                    w_ar_hs      = 1'b1;
                    w_rstate_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.RREADY) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Sampled on the AR edge from current register state, so a write
    // committing on the same edge is not yet visible.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (w_ar_sel.oor) begin
            w_rd_resp = RESP_SLVERR;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (w_ar_sel.idx == 32'(k)) begin
                    w_rd_data = r_reg[k];
                end
            end
            for (int k = 0; k < NUM_RO; k++) begin
                if (w_ar_sel.idx == 32'(NUM_RW + k)) begin
                    w_rd_data = w_ro_val[k];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign bus.ARREADY = w_arready;
    assign bus.RVALID  = (r_rstate == R_RESP);
    assign bus.RDATA   = r_rdata;
    assign bus.RRESP   = r_rresp;

endmodule

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

Parametrised AXI4-Lite slave register bank, successor to the fixed 4×32-bit register list IP. It provides NUM_RW read/write control registers followed by NUM_RO read-only status registers, with byte strobes, out-of-range error responses and per-register write pulses. It sits behind the AXI interconnect as the control/status window for a user core.

## Interface
- DATA_WIDTH, 32, register and AXI data width; 32 or 64.
- ADDR_WIDTH, 8, AXI address width.
- NUM_RW, 8, read/write registers at indices 0..NUM_RW-1; ≥1.
- NUM_RO, 4, read-only status registers at indices NUM_RW..NUM_RW+NUM_RO-1; ≥0.
- RST_VAL, 0, reset value of every RW register.

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels (ADDR_WIDTH, 3, DATA_WIDTH, DATA_WIDTH/8, 2).
- ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels.
- reg_q  out  NUM_RW*DATA_WIDTH  RW register contents; register k at [k*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_RW  one-cycle strobe for register k on every write commit to k.
- status_in  in  max(NUM_RO,1)*DATA_WIDTH  status sources, same packing.

## Operation
- Index = addr >> log2(DATA_WIDTH/8); low bits ignored. Index ≥ NUM_RW+NUM_RO → out of range.
- Write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP. AWREADY=1 in W_IDLE/W_HAVE_W; WREADY=1 in W_IDLE/W_HAVE_AW. AW and W accepted in either order or together; address/data/strobe latched.
- Commit on edge completing the later of the two handshakes: RW byte b updated if WSTRB[b]; reg_wr_pulse[k] high the following cycle; BRESP=OKAY, BVALID=1, go to W_RESP. Exit to W_IDLE on BVALID&BREADY.
- Write to RO index: no state change, BRESP=OKAY (see Configuration). Out of range: no effect, BRESP=SLVERR (2'b10).
- Read FSM: R_IDLE, R_RESP. ARREADY=1 only in R_IDLE. On AR handshake RDATA captured (RW: reg_q; RO: status_in/sticky value; out of range: 0, RRESP=SLVERR), RVALID=1. Exit on RVALID&RREADY.
- Read and write channels independent; one outstanding each.
- AWPROT/ARPROT ignored.

## Timing
- Reset (async assert, sync release): reg_q=RST_VAL, reg_wr_pulse=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, all READY=0 while ARESETN low, FSMs in IDLE.
- First cycle after release: AWREADY=WREADY=ARREADY=1.
- Write latency: BVALID asserted one cycle after the final AW/W handshake edge; reg_q updated on that same edge.
- Read latency: RVALID one cycle after the AR handshake edge.
- Read and write commit to same register on same edge: read returns pre-write value.
- BVALID/RVALID, BRESP/RRESP, RDATA held stable until accepted.
- Back-to-back: new AW/W/AR accepted no earlier than the cycle after the response handshake.
- Reset mid-transaction: transaction discarded, no response issued, registers return to RST_VAL.

## Configuration
- AXI_REG_BANK_W1C_EN defined: RO registers become sticky. Each cycle sticky |= status_in. A write with bit set (qualified by WSTRB) clears that bit, and the set term wins in the same cycle. Reset clears to 0.
- Undefined: RO registers read live status_in. Writes to RO indices are ignored with OKAY.

## Structure
- Package axi_reg_bank_pkg: resp encodings (OKAY=2'b00, SLVERR=2'b10), write/read FSM state enums, function computing index/out-of-range from address.
- Sub-module axi_reg_bank_wr_fsm: AW/W join logic and B channel, emitting a single commit strobe with latched addr/data/strobe. Read path and register array live in the top level.

## Test plan
- After reset: read index 0 → RDATA=RST_VAL, OKAY. Write 0x00000001..0x00000008 to 0x00..0x1C, read back → exact match, one reg_wr_pulse per write.
- Write 0xAABBCCDD to 0x04 with WSTRB=4'b0101 over 0x11223344 → reads 0x11BB33DD.
- W presented 3 cycles before AW, then AW before W → both commit correctly, BVALID one cycle after the later handshake.
- Read 0x30 (index 12, out of range with defaults) → RDATA=0, SLVERR; write there → SLVERR, reg_q unchanged.
- status_in[0]=0x5A5A0000 → read 0x20 returns it. With W1C: pulse status 0x1 then drop it → still reads 0x1; write 0x1 → reads 0.
- Hold BREADY/RREADY low 10 cycles → responses stable, no new AW/AR accepted. Assert ARESETN low mid-write → BVALID=0, reg_q=RST_VAL.
